// File: rtl/venus_dma_csr_regs_pkg.sv
// Shared VENUS DMA types, register offsets and CSR bank definitions.
// Optional feature macro used by the CSR bank: VENUSDMA_CSR_ALIGN_CHK_EN.

`ifndef VENUSDMA_CTRLREG_OFFSET
`define VENUSDMA_CTRLREG_OFFSET 32'h1FFE_0000
`endif
`ifndef VENUSDMA_CFG_OFFSET
`define VENUSDMA_CFG_OFFSET     6'h00
`endif
`ifndef VENUSDMA_SRC_OFFSET
`define VENUSDMA_SRC_OFFSET     6'h08
`endif
`ifndef VENUSDMA_DST_OFFSET
`define VENUSDMA_DST_OFFSET     6'h10
`endif
`ifndef VENUSDMA_LEN_OFFSET
`define VENUSDMA_LEN_OFFSET     6'h18
`endif
`ifndef VENUSDMA_STAT_OFFSET
`define VENUSDMA_STAT_OFFSET    6'h20
`endif
`ifndef VENUSDMA_ERRADDR_OFFSET
`define VENUSDMA_ERRADDR_OFFSET 6'h28
`endif
`ifndef VENUSDMA_ERRSRC_OFFSET
`define VENUSDMA_ERRSRC_OFFSET  6'h30
`endif

package venus_dma_csr_regs_pkg;

  typedef struct packed {
    logic        csr_wr_en;
    logic [31:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        csr_rd_en;
  } csr_req_t;

  typedef struct packed {
    logic [511:0] csr_rdata;
  } csr_resp_t;

  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] num_bytes;
    logic [31:0] dst_addr;
  } s_dma_desc_t;

  typedef enum logic [1:0] {
    DMA_NO_ERR        = 2'd0,
    DMA_AXI_WR_ERR    = 2'd1,
    DMA_UNALIGNED_ERR = 2'd2,
    DMA_AXI_RD_ERR    = 2'd3
  } dma_err_src_t;

  typedef struct packed {
    logic [31:0]  addr;
    dma_err_src_t src;
    logic         valid;
  } s_dma_error_t;

  typedef struct packed {
    logic active;
    logic done;
    logic error;
  } s_dma_status_t;

  typedef enum logic [1:0] {
    DMA_CSR_IDLE = 2'd0,
    DMA_CSR_RUN  = 2'd1,
    DMA_CSR_DONE = 2'd2,
    DMA_CSR_ERR  = 2'd3
  } dma_csr_st_t;

  localparam int unsigned DMA_CFG_GO_BIT    = 0;
  localparam int unsigned DMA_CFG_CLR_BIT   = 1;
  localparam int unsigned DMA_CFG_IRQEN_BIT = 2;

  // Least significant readback bit of the register at byte offset off.
  function automatic int unsigned lane_lsb(input logic [5:0] off);
    return 8 * int'(off);
  endfunction

endpackage

// File: rtl/venus_dma_csr_regs.sv
// VENUS DMA CSR register bank: write decode, transfer-control FSM and
// full-window registered readback. Optional build macro:
// VENUSDMA_CSR_ALIGN_CHK_EN (reject unaligned SRC/DST at GO time).

module venus_dma_csr_regs
  import venus_dma_csr_regs_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = `VENUSDMA_CTRLREG_OFFSET
) (
  input  logic          clk,
  input  logic          rst,
  input  csr_req_t      csr_req_i,
  output csr_resp_t     csr_resp_o,
  output s_dma_desc_t   dma_desc_o,
  output logic          dma_go_o,
  input  logic          dma_done_i,
  input  s_dma_error_t  dma_error_i,
  output s_dma_status_t dma_status_o,
  output logic          irq_o
);

  dma_csr_st_t  state_q;
  logic         go_q;
  logic         irq_en_q;
  logic [31:0]  src_q, dst_q, len_q;
  logic [31:0]  erraddr_q, errsrc_q;
  logic [511:0] rdata_q;
  logic [511:0] rdata_d;

  logic        wr_hit, cfg_wr, go_cmd, clr_cmd;
  logic [5:0]  wr_off;
  logic [31:0] wdata;
  logic        align_bad;
  logic [31:0] align_addr;

  assign wr_hit = csr_req_i.csr_wr_en && (csr_req_i.csr_waddr[31:6] == BASE_ADDR[31:6]);
  assign wr_off = csr_req_i.csr_waddr[5:0];
  assign wdata  = csr_req_i.csr_wdata;
  assign cfg_wr = wr_hit && (wr_off == `VENUSDMA_CFG_OFFSET);
  // GO wins over CLR when both are written in the same word.
  assign go_cmd  = cfg_wr && wdata[DMA_CFG_GO_BIT];
  assign clr_cmd = cfg_wr && wdata[DMA_CFG_CLR_BIT] && !wdata[DMA_CFG_GO_BIT];

`ifdef VENUSDMA_CSR_ALIGN_CHK_EN
  assign align_bad  = (src_q[1:0] != 2'b00) || (dst_q[1:0] != 2'b00);
  assign align_addr = (src_q[1:0] != 2'b00) ? src_q : dst_q;
`else
  assign align_bad  = 1'b0;
  assign align_addr = src_q;
`endif

  // Config and descriptor registers; the descriptor is frozen during RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
    end else begin
      if (cfg_wr) irq_en_q <= wdata[DMA_CFG_IRQEN_BIT];
      if (wr_hit && state_q != DMA_CSR_RUN) begin
        unique case (wr_off)
          `VENUSDMA_SRC_OFFSET: src_q <= wdata;
          `VENUSDMA_DST_OFFSET: dst_q <= wdata;
          `VENUSDMA_LEN_OFFSET: len_q <= wdata;
          default: ;
        endcase
      end
    end
  end

  // Transfer FSM with registered launch pulse and error capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DMA_CSR_IDLE;
      go_q      <= 1'b0;
      erraddr_q <= '0;
      errsrc_q  <= '0;
    end else begin
      go_q <= 1'b0;
      unique case (state_q)
        DMA_CSR_RUN: begin
          if (dma_error_i.valid) begin
            state_q   <= DMA_CSR_ERR;
            erraddr_q <= dma_error_i.addr;
            errsrc_q  <= {30'd0, dma_error_i.src};
          end else if (dma_done_i) begin
            state_q <= DMA_CSR_DONE;
          end
        end
        default: begin
          if (go_cmd) begin
            if (len_q == 32'd0) begin
              state_q <= DMA_CSR_DONE;
            end else if (align_bad) begin
              state_q   <= DMA_CSR_ERR;
              erraddr_q <= align_addr;
              errsrc_q  <= {30'd0, DMA_UNALIGNED_ERR};
            end else begin
              state_q   <= DMA_CSR_RUN;
              go_q      <= 1'b1;
              erraddr_q <= '0;
              errsrc_q  <= '0;
            end
          end else if (clr_cmd) begin
            state_q   <= DMA_CSR_IDLE;
            erraddr_q <= '0;
            errsrc_q  <= '0;
          end
        end
      endcase
    end
  end

  // Snapshot of the whole 64-byte window as it stands before this edge.
  always_comb begin
    rdata_d = '0;
    rdata_d[lane_lsb(`VENUSDMA_CFG_OFFSET)     +: 32] = {29'd0, irq_en_q, 2'b00};
    rdata_d[lane_lsb(`VENUSDMA_SRC_OFFSET)     +: 32] = src_q;
    rdata_d[lane_lsb(`VENUSDMA_DST_OFFSET)     +: 32] = dst_q;
    rdata_d[lane_lsb(`VENUSDMA_LEN_OFFSET)     +: 32] = len_q;
    rdata_d[lane_lsb(`VENUSDMA_STAT_OFFSET)    +: 32] = {29'd0, state_q == DMA_CSR_ERR,
                                                         state_q == DMA_CSR_DONE,
                                                         state_q == DMA_CSR_RUN};
    rdata_d[lane_lsb(`VENUSDMA_ERRADDR_OFFSET) +: 32] = erraddr_q;
    rdata_d[lane_lsb(`VENUSDMA_ERRSRC_OFFSET)  +: 32] = errsrc_q;
  end

  // Readback register; holds until the next read.
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else if (csr_req_i.csr_rd_en) rdata_q <= rdata_d;
  end

  assign csr_resp_o.csr_rdata = rdata_q;
  assign dma_desc_o.src_addr  = src_q;
  assign dma_desc_o.num_bytes = len_q;
  assign dma_desc_o.dst_addr  = dst_q;
  assign dma_go_o             = go_q;
  assign dma_status_o.active  = (state_q == DMA_CSR_RUN);
  assign dma_status_o.done    = (state_q == DMA_CSR_DONE);
  assign dma_status_o.error   = (state_q == DMA_CSR_ERR);
  assign irq_o = irq_en_q && (dma_status_o.done || dma_status_o.error);

endmodule

// File: tb/tb_venus_dma_csr_regs.sv
// Scoreboard bench for venus_dma_csr_regs: stimulus pushes expected read
// responses, an independent monitor pops and compares them.

module tb_venus_dma_csr_regs;
  import venus_dma_csr_regs_pkg::*;

  localparam logic [31:0] BASE = 32'h1FFE_0000;
  localparam logic [31:0] A_CFG = BASE + 32'h00;
  localparam logic [31:0] A_SRC = BASE + 32'h08;
  localparam logic [31:0] A_DST = BASE + 32'h10;
  localparam logic [31:0] A_LEN = BASE + 32'h18;

  logic          clk = 1'b0;
  logic          rst;
  csr_req_t      req;
  csr_resp_t     resp;
  s_dma_desc_t   desc;
  logic          go;
  logic          done;
  s_dma_error_t  err;
  s_dma_status_t st;
  logic          irq;

  typedef struct {
    string        name;
    logic [511:0] win;
    logic [2:0]   stat;
    logic         irq;
    int           go;
    logic [95:0]  desc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_go = 0;
  int   go_seen = 0;

  always #5 clk = ~clk;

  venus_dma_csr_regs #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .csr_req_i(req), .csr_resp_o(resp),
    .dma_desc_o(desc), .dma_go_o(go), .dma_done_i(done),
    .dma_error_i(err), .dma_status_o(st), .irq_o(irq)
  );

  function automatic logic [511:0] mk_win(input logic [31:0] cfg, src, dst, len,
                                          input logic [2:0] stat, input logic [31:0] ea, es);
    logic [511:0] w;
    w = '0;
    w[31:0]    = cfg;
    w[95:64]   = src;
    w[159:128] = dst;
    w[223:192] = len;
    w[287:256] = {29'd0, stat};
    w[351:320] = ea;
    w[415:384] = es;
    return w;
  endfunction

  task automatic push(input string nm, input logic [31:0] cfg, src, dst, len,
                      input logic [2:0] stat, input logic [31:0] ea, es,
                      input logic irq_e, input logic [31:0] dsrc);
    exp_t e;
    e.name = nm;
    e.win  = mk_win(cfg, src, dst, len, stat, ea, es);
    e.stat = stat;
    e.irq  = irq_e;
    e.go   = exp_go;
    e.desc = {dsrc, len, dst};
    exp_q.push_back(e);
  endtask

  // Drivers assume they start #1 after a rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    req.csr_wr_en = 1'b1; req.csr_waddr = a; req.csr_wdata = d;
    @(posedge clk); #1;
    req.csr_wr_en = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [31:0] cfg, src, dst, len,
                    input logic [2:0] stat, input logic [31:0] ea, es, input logic irq_e);
    push(nm, cfg, src, dst, len, stat, ea, es, irq_e, src);
    req.csr_rd_en = 1'b1;
    @(posedge clk); #1;
    req.csr_rd_en = 1'b0;
  endtask

  task automatic pulse(input logic dn, input logic ev, input logic [31:0] ea, input logic [1:0] es);
    done = dn; err.valid = ev; err.addr = ea; err.src = dma_err_src_t'(es);
    @(posedge clk); #1;
    done = 1'b0; err = '0;
  endtask

  // Monitor: the response is present on the falling edge after a sampled read.
  initial begin
    logic pend;
    exp_t e;
    forever begin
      @(posedge clk);
      pend = req.csr_rd_en;
      @(negedge clk);
      if (go) go_seen++;
      if (pend) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_read: got response, want none queued");
        end else begin
          e = exp_q.pop_front();
          if (resp.csr_rdata !== e.win) begin
            errors++;
            $display("FAIL %s window: got %h want %h", e.name, resp.csr_rdata, e.win);
          end
          checks++;
          if ({st.error, st.done, st.active} !== e.stat) begin
            errors++;
            $display("FAIL %s status: got %b want %b", e.name, {st.error, st.done, st.active}, e.stat);
          end
          checks++;
          if (irq !== e.irq) begin
            errors++;
            $display("FAIL %s irq: got %b want %b", e.name, irq, e.irq);
          end
          checks++;
          if (go_seen != e.go) begin
            errors++;
            $display("FAIL %s go_count: got %0d want %0d", e.name, go_seen, e.go);
          end
          checks++;
          if (desc !== e.desc) begin
            errors++;
            $display("FAIL %s desc: got %h want %h", e.name, desc, e.desc);
          end
          $display("read %s checked (go pulses %0d)", e.name, go_seen);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req = '0; done = 1'b0; err = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    rd("reset", 0, 0, 0, 0, 3'b000, 0, 0, 0);
    wr(A_SRC, 32'h1000); wr(A_DST, 32'h2000); wr(A_LEN, 32'h40);
    rd("desc_write", 0, 32'h1000, 32'h2000, 32'h40, 3'b000, 0, 0, 0);
    wr(A_CFG, 32'h1); exp_go++;
    rd("go_launch", 0, 32'h1000, 32'h2000, 32'h40, 3'b001, 0, 0, 0);
    wr(A_SRC, 32'hdead); wr(A_CFG, 32'h1);
    rd("run_locked", 0, 32'h1000, 32'h2000, 32'h40, 3'b001, 0, 0, 0);
    pulse(1'b1, 1'b0, 0, 0);
    rd("done", 0, 32'h1000, 32'h2000, 32'h40, 3'b010, 0, 0, 0);
    wr(A_CFG, 32'h4);
    rd("irq_en", 32'h4, 32'h1000, 32'h2000, 32'h40, 3'b010, 0, 0, 1);
    wr(A_CFG, 32'h6);
    rd("clr_done", 32'h4, 32'h1000, 32'h2000, 32'h40, 3'b000, 0, 0, 0);
    wr(A_LEN, 32'h0); wr(A_CFG, 32'h5);
    rd("go_len0", 32'h4, 32'h1000, 32'h2000, 32'h0, 3'b010, 0, 0, 1);
    wr(A_LEN, 32'h40); wr(A_CFG, 32'h5); exp_go++;
    pulse(1'b1, 1'b1, 32'h3000, 2'd1);
    rd("err_and_done", 32'h4, 32'h1000, 32'h2000, 32'h40, 3'b100, 32'h3000, 32'h1, 1);
    pulse(1'b1, 1'b1, 32'h5555, 2'd3);
    rd("err_outside_run", 32'h4, 32'h1000, 32'h2000, 32'h40, 3'b100, 32'h3000, 32'h1, 1);
    wr(A_CFG, 32'h6);
    rd("clr_err", 32'h4, 32'h1000, 32'h2000, 32'h40, 3'b000, 0, 0, 0);
    wr(A_CFG, 32'h7); exp_go++;
    rd("go_beats_clr", 32'h4, 32'h1000, 32'h2000, 32'h40, 3'b001, 0, 0, 0);
    pulse(1'b1, 1'b0, 0, 0);
    rd("done2", 32'h4, 32'h1000, 32'h2000, 32'h40, 3'b010, 0, 0, 1);
    wr(BASE + 32'h48, 32'h7777); wr(32'h2FFE_0008, 32'h8888);
    wr(BASE + 32'h20, 32'h7); wr(BASE + 32'h28, 32'h99); wr(BASE + 32'h38, 32'hAA);
    rd("ignored_writes", 32'h4, 32'h1000, 32'h2000, 32'h40, 3'b010, 0, 0, 1);

    // Read and write in the same cycle: window holds the old SRC.
    push("rd_wr_same", 32'h4, 32'h1000, 32'h2000, 32'h40, 3'b010, 0, 0, 1, 32'h4000);
    req.csr_rd_en = 1'b1;
    wr(A_SRC, 32'h4000);
    req.csr_rd_en = 1'b0;
    rd("after_rd_wr", 32'h4, 32'h4000, 32'h2000, 32'h40, 3'b010, 0, 0, 1);

`ifdef VENUSDMA_CSR_ALIGN_CHK_EN
    wr(A_SRC, 32'h1002); wr(A_CFG, 32'h5);
    rd("unaligned_src", 32'h4, 32'h1002, 32'h2000, 32'h40, 3'b100, 32'h1002, 32'h2, 1);
    wr(A_CFG, 32'h6); wr(A_SRC, 32'h1000); wr(A_DST, 32'h2002); wr(A_CFG, 32'h5);
    rd("unaligned_dst", 32'h4, 32'h1000, 32'h2002, 32'h40, 3'b100, 32'h2002, 32'h2, 1);
`else
    wr(A_SRC, 32'h1002); wr(A_CFG, 32'h5); exp_go++;
    rd("unaligned_launch", 32'h4, 32'h1002, 32'h2000, 32'h40, 3'b001, 0, 0, 0);
    pulse(1'b1, 1'b0, 0, 0);
    rd("unaligned_done", 32'h4, 32'h1002, 32'h2000, 32'h40, 3'b010, 0, 0, 1);
`endif
    wr(A_CFG, 32'h6); wr(A_SRC, 32'h1000); wr(A_DST, 32'h2000);
    rd("restore", 32'h4, 32'h1000, 32'h2000, 32'h40, 3'b000, 0, 0, 0);

    // Reset while running: back to IDLE with no further launch pulse.
    wr(A_CFG, 32'h5); exp_go++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rd("rst_in_run", 0, 0, 0, 0, 3'b000, 0, 0, 0);

    repeat (5) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_reads: got %0d unanswered want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/venus_dma_csr_regs.md
# venus_dma_csr_regs

DMA control/status register bank: the responder end of the `csr_req_t`/`csr_resp_t` CSR interface. It decodes CSR writes into descriptor and config registers and launches one transfer per GO command toward the DMA FSM/streamer. It latches done/error status back from the datapath and returns the whole 64-byte register window on every read.

## Interface
- `BASE_ADDR`, default `` `VENUSDMA_CTRLREG_OFFSET ``: register window base, 64-byte aligned.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `csr_req_i`  in  `csr_req_t`  write and read requests; every write covers a full 32-bit word.
- `csr_resp_o`  out  `csr_resp_t`  512-bit readback of the register window.
- `dma_desc_o`  out  `s_dma_desc_t`  descriptor, held stable while a transfer runs.
- `dma_go_o`  out  1  one-cycle transfer launch pulse.
- `dma_done_i`  in  1  one-cycle pulse: transfer complete.
- `dma_error_i`  in  `s_dma_error_t`  error report; `valid` is a one-cycle pulse.
- `dma_status_o`  out  `s_dma_status_t`  active/done/error levels.
- `irq_o`  out  1  interrupt level.

## Operation
**Address decode**
- A write is accepted only if `csr_waddr[31:6] == BASE_ADDR[31:6]`. Other writes are ignored.
- The register is selected by `csr_waddr[5:0]`.
- Offsets: CFG 0x00, SRC 0x08, DST 0x10, LEN 0x18, STAT 0x20, ERRADDR 0x28, ERRSRC 0x30.
- Writes to STAT, ERRADDR, ERRSRC or any undefined offset are ignored.

**CFG register**
- bit0 GO: write-1 pulse; never stored.
- bit1 CLR: write-1 pulse; never stored.
- bit2 IRQ_EN: stored.
- Bits [31:3] read as 0.

**Descriptor registers**
- SRC, DST and LEN drive `dma_desc_o` directly.
- Writes to SRC, DST or LEN are ignored while the state is RUN.

**State machine (states: IDLE, RUN, DONE, ERR)**
- IDLE/DONE/ERR + GO with LEN≠0 → RUN. `dma_go_o`=1 for the next cycle only. In the same transition, done, error, ERRADDR and ERRSRC are cleared.
- IDLE/DONE/ERR + GO with LEN=0 → DONE. No `dma_go_o` pulse.
- RUN + `dma_error_i.valid` → ERR. ERRADDR←`addr` and ERRSRC←zero-extended `src`. This applies even if `dma_done_i` is asserted in the same cycle.
- RUN + `dma_done_i` alone → DONE.
- DONE/ERR + CLR → IDLE; ERRADDR and ERRSRC are cleared.
- GO and CLR written in the same word: GO takes precedence.
- GO or CLR while in RUN: ignored.
- `dma_done_i` or `dma_error_i` outside RUN: ignored. Only the first error of a transfer is latched.

**Status outputs**
- STAT: bit0 active (RUN), bit1 done (DONE), bit2 error (ERR). `dma_status_o` carries the same values.
- `irq_o` = IRQ_EN & (done | error).

**Readback**
- On `csr_rd_en`, `csr_rdata` is loaded with the snapshot of all registers.
- Register at byte offset n occupies `csr_rdata[8n+31:8n]`. Unused bits are 0.

## Timing
- Reset values: all registers 0, state IDLE, `dma_go_o`=0, `irq_o`=0, `csr_rdata`=0, `dma_status_o`=0.
- Write latency: a register write is visible on its output one cycle after `csr_wr_en`.
- GO latency: `dma_go_o` asserts one cycle after the GO write and `active` asserts in that same cycle.
- Read latency: `csr_rdata` is registered and valid one cycle after `csr_rd_en`. It holds until the next read.
- Write and read in the same cycle: the read returns the pre-write values.
- Done/error latency: on `dma_done_i` or `dma_error_i.valid`, state and STAT update on the next edge.
- No backpressure: every request completes in one cycle.
- `rst` during RUN: return to IDLE with no further `dma_go_o` pulse. The DMA datapath is reset by the same `rst`.

## Configuration
- Macro: `VENUSDMA_CSR_ALIGN_CHK_EN`.
- Defined: a GO with LEN≠0 is checked for alignment before launch.
  - If `SRC[1:0]≠0`, go directly to ERR with no `dma_go_o`. ERRSRC=`DMA_UNALIGNED_ERR` and ERRADDR=SRC.
  - Otherwise, if `DST[1:0]≠0`, the same applies with ERRADDR=DST.
- Undefined: no alignment check; every GO with LEN≠0 launches.

## Structure
- Shared package additions:
  - `dma_csr_st_t` enum with the four states.
  - Localparams `DMA_CFG_GO_BIT`=0, `DMA_CFG_CLR_BIT`=1, `DMA_CFG_IRQEN_BIT`=2.
- Offsets reuse the existing `VENUSDMA_*_OFFSET` defines.
- No sub-module: decode, FSM and readback form a single module.

## Test plan
- Write SRC=0x1000, DST=0x2000, LEN=0x40, then CFG=0x1 → `dma_go_o` pulses for one cycle and `dma_desc_o`={0x1000,0x40,0x2000}. After `dma_done_i`, STAT reads 0x2.
- GO with LEN=0 → no `dma_go_o` pulse; STAT=0x2. With IRQ_EN set, `irq_o`=1.
- In RUN, assert `dma_error_i`={addr 0x3000, DMA_AXI_WR_ERR, valid} together with `dma_done_i` → STAT=0x4, ERRADDR=0x3000, ERRSRC=1. CLR → STAT=0, ERRADDR=0.
- In RUN, write SRC=0xdead and CFG=0x1 → SRC is unchanged and there is no second `dma_go_o`.
- Write to 0x1ffe_0040 or to a different base → no register changes. A read returns SRC at `csr_rdata[95:64]`.
- With `VENUSDMA_CSR_ALIGN_CHK_EN` defined, SRC=0x1002 plus GO → ERR with ERRSRC=2, ERRADDR=0x1002 and no `dma_go_o`. Undefined → launches normally.
